// File: rtl/irq_enc_pkg.sv
// Shared types for the 8-line interrupt request encoder.
// Index/vector widths, FSM state encoding and a one-hot helper.
// No logic; imported by the encoder and its priority sub-block.
package irq_enc_pkg;
  localparam int NREQ = 8;
  localparam int IDXW = $clog2(NREQ);

  typedef logic [IDXW-1:0] idx_t;
  typedef logic [NREQ-1:0] req_vec_t;
  typedef enum logic {IDLE, PRESENT} enc_state_t;

  function automatic req_vec_t onehot(input idx_t i);
    onehot = req_vec_t'(1) << i;
  endfunction
endpackage

// File: rtl/prio_enc8_3.sv
// Combinational priority encoder: index of the highest set bit of v, plus any-set flag.
// Latency: zero (pure combinational).
// Backpressure: none; output follows input.
module prio_enc8_3
  import irq_enc_pkg::*;
(
  input  logic [NREQ-1:0] v,
  output logic [IDXW-1:0] i,
  output logic            any
);

  // Ascending scan: the last hit is the highest index.
  always_comb begin
    i   = '0;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (v[k]) begin
        i   = idx_t'(k);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_encoder8_3.sv
// Latches 8 request lines as pending and presents the winning index via valid/ready.
// Latency: req sampled at edge -> pending; next edge -> valid/idx. One bubble after each accept.
// Backpressure: idx/valid held while !ready; IRQ_ENC_ROUND_ROBIN_EN selects rotating priority.
module irq_encoder8_3
  import irq_enc_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  output logic [IDXW-1:0] idx,
  output logic            valid,
  input  logic            ready,
  output logic [NREQ-1:0] pend
);

  enc_state_t state, state_nxt;
  req_vec_t   pending, clr, cand, enc_in;
  idx_t       idx_q, idx_nxt, enc_idx, win;
  logic       enc_any, accept;

  assign accept = (state == PRESENT) && ready;
  assign clr    = accept ? onehot(idx_q) : '0;
  assign cand   = pending & mask;

`ifdef IRQ_ENC_ROUND_ROBIN_EN
  // rr_ptr holds the last served index; the search starts one below it and wraps,
  // so the line just served becomes the lowest priority.
  idx_t               rr_ptr;
  logic [2*NREQ-1:0]  cand_dbl;

  assign cand_dbl = {cand, cand};
  assign enc_in   = cand_dbl[rr_ptr +: NREQ];
  assign win      = enc_idx + rr_ptr;

  always_ff @(posedge clk) begin
    if (reset)       rr_ptr <= '0;
    else if (accept) rr_ptr <= idx_q;
  end
`else
  assign enc_in = cand;
  assign win    = enc_idx;
`endif

  prio_enc8_3 u_prio (
    .v   (enc_in),
    .i   (enc_idx),
    .any (enc_any)
  );

  // Arbitration happens only in IDLE; a presented index is never retracted.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    case (state)
      IDLE: begin
        if (enc_any) begin
          idx_nxt   = win;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (ready) state_nxt = IDLE;
      end
    endcase
  end

  // A new request on the line being cleared wins, so it is presented again later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
      idx_q   <= '0;
    end else begin
      state   <= state_nxt;
      pending <= (pending & ~clr) | req;
      idx_q   <= idx_nxt;
    end
  end

  assign valid = (state == PRESENT);
  assign idx   = idx_q;
  assign pend  = pending;

  a_nreq_fixed: assert property (@(posedge clk) (NREQ == 8) && (IDXW == 3));

endmodule
